per_gpio_in_filter: RTL and testbench

//  Input conditioning stage placed directly upstream of the GPIO peripheral:

---
 rtl/per_gpio_in_filter.sv | 172 +++++++++++++++++
 tb/tb_per_gpio_in_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/per_gpio_in_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// per_gpio_in_filter : pin synchroniser/debouncer with W1C edge flags and IRQ.
// Debounce logic is built only when PER_GPIO_IN_DEBOUNCE_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
module per_gpio_in_filter #(
  parameter int WIDTH        = 32,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [15:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  input  logic [1:0]       size_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_in_o,
  output logic             irq_o
);

  localparam logic [15:0] ADDR_STATE  = 16'h0000;
  localparam logic [15:0] ADDR_RISE   = 16'h0004;
  localparam logic [15:0] ADDR_FALL   = 16'h0008;
  localparam logic [15:0] ADDR_MASK_R = 16'h000c;
  localparam logic [15:0] ADDR_MASK_F = 16'h0010;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] gpio_in_q, gpio_in_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] mask_r_q, mask_r_d;
  logic [WIDTH-1:0] mask_f_q, mask_f_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_bits;

  always_comb begin
    sync_d[0] = pins_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

`ifdef PER_GPIO_IN_DEBOUNCE_EN
  localparam int PW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DEBOUNCE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // A pin that matches its filtered level restarts qualification; a
  // mismatching pin accumulates ticks and flips on the last one.
  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    gpio_in_d = gpio_in_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == gpio_in_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          gpio_in_d[i] = s[i];
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign unused_bits = ^{size_i, wdata_i};
`else
  always_comb begin
    gpio_in_d = s;
  end

  assign unused_bits = ^{size_i, wdata_i, 1'(DEBOUNCE_DIV), 1'(DEBOUNCE_CNT)};
`endif

  // Set is OR-ed in after the W1C clear so a coincident event survives.
  always_comb begin
    rise_d   = rise_q;
    fall_d   = fall_q;
    mask_r_d = mask_r_q;
    mask_f_d = mask_f_q;
    rdata_d  = rdata_q;
    if (wr_i) begin
      case (addr_i)
        ADDR_RISE:   rise_d   = rise_q & ~wdata_i[WIDTH-1:0];
        ADDR_FALL:   fall_d   = fall_q & ~wdata_i[WIDTH-1:0];
        ADDR_MASK_R: mask_r_d = wdata_i[WIDTH-1:0];
        ADDR_MASK_F: mask_f_d = wdata_i[WIDTH-1:0];
        default: ;
      endcase
    end
    rise_d = rise_d | (gpio_in_d & ~gpio_in_q);
    fall_d = fall_d | (~gpio_in_d & gpio_in_q);
    if (rd_i) begin
      case (addr_i)
        ADDR_STATE:  rdata_d = 32'(gpio_in_q);
        ADDR_RISE:   rdata_d = 32'(rise_q);
        ADDR_FALL:   rdata_d = 32'(fall_q);
        ADDR_MASK_R: rdata_d = 32'(mask_r_q);
        ADDR_MASK_F: rdata_d = 32'(mask_f_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gpio_in_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      mask_r_q  <= '0;
      mask_f_q  <= '0;
      rdata_q   <= '0;
    end else begin
      gpio_in_q <= gpio_in_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      mask_r_q  <= mask_r_d;
      mask_f_q  <= mask_f_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gpio_in_o = gpio_in_q;
  assign rdata_o   = rdata_q;
  assign irq_o     = |((rise_q & mask_r_q) | (fall_q & mask_f_q));

endmodule
`default_nettype wire

// File: tb/tb_per_gpio_in_filter.sv
`default_nettype none
// Bench for per_gpio_in_filter: reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_per_gpio_in_filter;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int DIV   = 4;
  localparam int CNT   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       addr_i = '0;
  logic [31:0]       wdata_i = '0;
  logic [31:0]       rdata_o;
  logic [1:0]        size_i = 2'b10;
  logic              rd_i = 1'b0;
  logic              wr_i = 1'b0;
  logic [WIDTH-1:0]  pins_i = '0;
  logic [WIDTH-1:0]  gpio_in_o;
  logic              irq_o;

  int checks = 0;
  int errors = 0;

  per_gpio_in_filter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_DIV(DIV), .DEBOUNCE_CNT(CNT)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .size_i(size_i), .rd_i(rd_i), .wr_i(wr_i),
    .pins_i(pins_i), .gpio_in_o(gpio_in_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_gpio, m_rise, m_fall, m_mr, m_mf, m_rdata;
  logic [31:0] pin_hist[$];
  int          ticks_seen[WIDTH];
  longint      edge_idx;

  function automatic logic [31:0] m_reg(input logic [15:0] a);
    case (a)
      16'h0000: return m_gpio;
      16'h0004: return m_rise;
      16'h0008: return m_fall;
      16'h000c: return m_mr;
      16'h0010: return m_mf;
      default:  return 32'h0;
    endcase
  endfunction

  initial begin : model
    logic [31:0] s_now, ng, clr_r, clr_f;
    bit          tk;
    m_gpio = 0; m_rise = 0; m_fall = 0; m_mr = 0; m_mf = 0; m_rdata = 0;
    edge_idx = 0;
    foreach (ticks_seen[i]) ticks_seen[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_gpio = 0; m_rise = 0; m_fall = 0; m_mr = 0; m_mf = 0; m_rdata = 0;
        pin_hist.delete();
        edge_idx = 0;
        foreach (ticks_seen[i]) ticks_seen[i] = 0;
      end else begin
        // synchronised level = pins as sampled SYNC edges ago
        s_now = (pin_hist.size() >= SYNC) ? pin_hist[pin_hist.size()-SYNC] : 32'h0;
`ifdef PER_GPIO_IN_DEBOUNCE_EN
        tk = ((edge_idx % DIV) == DIV - 1);
        ng = m_gpio;
        for (int i = 0; i < WIDTH; i++) begin
          if (s_now[i] == m_gpio[i]) ticks_seen[i] = 0;
          else if (tk) begin
            ticks_seen[i]++;
            if (ticks_seen[i] == CNT) begin
              ng[i] = s_now[i];
              ticks_seen[i] = 0;
            end
          end
        end
`else
        tk = 1'b0;
        ng = s_now;
`endif
        if (rd_i) m_rdata = m_reg(addr_i);
        clr_r = (wr_i && addr_i == 16'h0004) ? wdata_i : 32'h0;
        clr_f = (wr_i && addr_i == 16'h0008) ? wdata_i : 32'h0;
        m_rise = (m_rise & ~clr_r) | (ng & ~m_gpio);
        m_fall = (m_fall & ~clr_f) | (~ng & m_gpio);
        if (wr_i && addr_i == 16'h000c) m_mr = wdata_i;
        if (wr_i && addr_i == 16'h0010) m_mf = wdata_i;
        m_gpio = ng;
        pin_hist.push_back(pins_i);
        if (pin_hist.size() > 8) void'(pin_hist.pop_front());
        edge_idx++;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("gpio_in", gpio_in_o, m_gpio);
      chk("irq", {31'h0, irq_o}, {31'h0, |((m_rise & m_mr) | (m_fall & m_mf))});
      chk("rdata", rdata_o, m_rdata);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; wdata_i = d; wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic wait_gpio(input logic [31:0] m, input logic [31:0] v, input string name);
    for (int n = 0; n < 100; n++) begin
      if ((gpio_in_o & m) == v) break;
      @(negedge clk);
    end
    chk(name, gpio_in_o & m, v);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] r;
    logic [15:0] addrs[7];
    int          n;
    bit          hit;
    addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h000c, 16'h0010, 16'h0014, 16'h1004};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_gpio", gpio_in_o, 32'h0);
    chk("reset_irq", {31'h0, irq_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);

`ifdef PER_GPIO_IN_DEBOUNCE_EN
    // qualification window for a clean rising pin
    pins_i = 32'h1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (gpio_in_o[0]) break;
    end
    chk("rise_latency_in_11_to_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
    bus_rd(16'h0004, r); chk("rise_after_qualify", r, 32'h1);
    bus_rd(16'h0008, r); chk("fall_after_qualify", r, 32'h0);
    // short glitch must not qualify
    pins_i[5] = 1'b1;
    repeat (6) @(negedge clk);
    pins_i[5] = 1'b0;
    hit = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (gpio_in_o[5]) hit = 1'b1;
    end
    chk("glitch_gpio5", {31'h0, hit}, 32'h0);
    bus_rd(16'h0004, r); chk("glitch_rise5", r & 32'h20, 32'h0);
    chk("glitch_irq", {31'h0, irq_o}, 32'h0);
`else
    // direct path: three edges from pin to filtered output
    pins_i = 32'hA5A5_0001;
    @(negedge clk); @(negedge clk);
    chk("latency_two_edges", gpio_in_o, 32'h0);
    @(negedge clk);
    chk("latency_three_edges", gpio_in_o, 32'hA5A5_0001);
    bus_rd(16'h0004, r); chk("rise_pattern", r, 32'hA5A5_0001);
    bus_rd(16'h0000, r); chk("state_pattern", r, 32'hA5A5_0001);
`endif

    pins_i = '0;
    wait_gpio(32'hFFFF_FFFF, 32'h0, "settle_low");
    bus_wr(16'h0004, 32'hFFFF_FFFF);
    bus_wr(16'h0008, 32'hFFFF_FFFF);
    bus_rd(16'h0004, r); chk("rise_cleared", r, 32'h0);
    bus_rd(16'h0008, r); chk("fall_cleared", r, 32'h0);

    // falling-edge IRQ on pin 7 and its W1C acknowledge
    pins_i = 32'h80;
    wait_gpio(32'h80, 32'h80, "pin7_high");
    bus_wr(16'h0004, 32'hFFFF_FFFF);
    bus_wr(16'h0010, 32'h80);
    bus_rd(16'h0010, r); chk("mask_f_readback", r, 32'h80);
    pins_i = 32'h0;
    wait_gpio(32'h80, 32'h0, "pin7_low");
    chk("fall_irq_high", {31'h0, irq_o}, 32'h1);
    bus_rd(16'h0008, r); chk("fall_flag", r, 32'h80);
    bus_wr(16'h0008, 32'h80);
    chk("fall_irq_cleared", {31'h0, irq_o}, 32'h0);
    bus_rd(16'h1010, r); chk("unmapped_read", r, 32'h0);

    // W1C of RISE[3] held on the very edge pin 3 qualifies
    pins_i = 32'h8;
    addr_i = 16'h0004; wdata_i = 32'h8; wr_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (gpio_in_o[3]) break;
    end
    wr_i = 1'b0;
    bus_rd(16'h0004, r); chk("set_beats_w1c", {31'h0, r[3]}, 32'h1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
`ifdef PER_GPIO_IN_DEBOUNCE_EN
      if ($urandom_range(0, 29) == 0) pins_i[$urandom_range(0, WIDTH-1)] ^= 1'b1;
`else
      if ($urandom_range(0, 3) == 0) pins_i = $urandom;
`endif
      rd_i    = ($urandom_range(0, 2) == 0);
      wr_i    = ($urandom_range(0, 3) == 0);
      addr_i  = addrs[$urandom_range(0, 6)];
      wdata_i = $urandom;
    end
    @(negedge clk);
    rd_i = 1'b0; wr_i = 1'b0;

    // reset asserted mid-operation with masks and flags live
    bus_wr(16'h000c, 32'hFFFF_FFFF);
    bus_wr(16'h0010, 32'hFFFF_FFFF);
    pins_i = 32'h5A5A_F00F;
    repeat (40) @(negedge clk);
    bus_rd(16'h0000, r);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_gpio", gpio_in_o, 32'h0);
    chk("async_reset_irq", {31'h0, irq_o}, 32'h0);
    chk("async_reset_rdata", rdata_o, 32'h0);
    pins_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_rd(16'h0004, r); chk("post_reset_rise", r, 32'h0);
    bus_rd(16'h0008, r); chk("post_reset_fall", r, 32'h0);
    bus_rd(16'h000c, r); chk("post_reset_mask_r", r, 32'h0);
    bus_rd(16'h0010, r); chk("post_reset_mask_f", r, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
